// File: rtl/nv_ram_rws_256x512_fifo_ctl_pkg.sv
// Shared geometry for the 256x512 rws-RAM FIFO controller.
// Pointer and counter widths derive from DEPTH so the two can never disagree.
package nv_ram_rws_256x512_fifo_ctl_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 512;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/nv_ram_rws_fifo_ptr.sv
// Wrapping RAM address pointer with increment and synchronous clear.
// Latency: updates at the edge after inc/clr; no backpressure, clr has priority.
module nv_ram_rws_fifo_ptr
    import nv_ram_rws_256x512_fifo_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output ptr_t ptr
);

    // DEPTH is a power of two, so the natural overflow wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ptr_t'(1);
        end
    end

endmodule

// File: rtl/nv_ram_rws_256x512_fifo_ctl.sv
// In-order FIFO sequencer around a 256x512 rws RAM (1 write port, registered read address).
// Latency: push visible on rd_pvld two cycles later; pops stall on rd_prdy, pushes stall when full.
module nv_ram_rws_256x512_fifo_ctl
    import nv_ram_rws_256x512_fifo_ctl_pkg::*;
(
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    input  logic          flush,
    output logic [AW:0]   occupancy,
    output logic          idle,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout
);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t occ;
    cnt_t avail;
    logic push;
    logic pop;

    // Reset gates ready directly: occ reads 0 while in reset, which would otherwise look like room.
    assign wr_prdy = nvdla_core_rstn & (occ != cnt_t'(DEPTH)) & !flush;
    assign push    = wr_pvld & wr_prdy;
    assign pop     = rd_pvld & rd_prdy;

    // avail excludes this cycle's push, so a read never targets the address being written.
    assign ram_re  = (avail != '0) & (!rd_pvld | rd_prdy) & !flush;

    assign ram_we    = push;
    assign ram_wa    = wr_ptr;
    assign ram_di    = wr_pd;
    assign ram_ra    = rd_ptr;
    assign rd_pd     = ram_dout;
    assign occupancy = occ;
    assign idle      = (occ == '0) & !rd_pvld;

    nv_ram_rws_fifo_ptr u_wr_ptr (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    nv_ram_rws_fifo_ptr u_rd_ptr (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .inc   (ram_re),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            occ     <= '0;
            avail   <= '0;
            rd_pvld <= 1'b0;
        end else if (flush) begin
            occ     <= '0;
            avail   <= '0;
            rd_pvld <= 1'b0;
        end else begin
            occ   <= occ + cnt_t'(push) - cnt_t'(pop);
            avail <= avail + cnt_t'(push) - cnt_t'(ram_re);
            if (ram_re) begin
                rd_pvld <= 1'b1;
            end else if (pop) begin
                rd_pvld <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(push && occ == cnt_t'(DEPTH)));

    a_pd_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (rd_pvld && !rd_prdy && !flush) |=> $stable(rd_pd));

    a_avail_le_occ: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        avail <= occ);
`endif

endmodule

// File: tb/tb_nv_ram_rws_256x512_fifo_ctl.sv
// Directed bench for the rws-RAM FIFO controller with a behavioural RAM model.
module tb_nv_ram_rws_256x512_fifo_ctl;
    import nv_ram_rws_256x512_fifo_ctl_pkg::*;

    logic          clk;
    logic          rstn;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          flush;
    logic [AW:0]   occupancy;
    logic          idle;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    nv_ram_rws_256x512_fifo_ctl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .flush           (flush),
        .occupancy       (occupancy),
        .idle            (idle),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_dout        (ram_dout)
    );

    // RAM model: synchronous write, latched read address, combinational data out.
    logic [DW-1:0] mem [DEPTH];
    ptr_t          ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        pat = {16{32'(i) ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_pd;
    int            sent, rcvd, wraps, cyc;
    logic          fill_ok, occ_ok;

    initial begin
        rstn = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0; flush = 1'b0;
        #1 rstn = 1'b0; wr_pvld = 1'b1; rd_prdy = 1'b1;
        #1;
        chk("rst_wr_prdy",   DW'(wr_prdy),   '0);
        chk("rst_ram_we",    DW'(ram_we),    '0);
        chk("rst_ram_re",    DW'(ram_re),    '0);
        chk("rst_occupancy", DW'(occupancy), '0);
        chk("rst_rd_pvld",   DW'(rd_pvld),   '0);
        chk("rst_idle",      DW'(idle),      DW'(1));
        wr_pvld = 1'b0; rd_prdy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        step();

        // Latency: single push into empty FIFO
        wr_pvld = 1'b1; wr_pd = pat(1000); #1;
        chk("lat_ram_we", DW'(ram_we), DW'(1));
        chk("lat_ram_wa", DW'(ram_wa), '0);
        chk("lat_ram_di", ram_di, pat(1000));
        chk("lat_re_n0",  DW'(ram_re), '0);
        step(); wr_pvld = 1'b0; #1;
        chk("lat_ram_re",   DW'(ram_re),  DW'(1));
        chk("lat_ram_ra",   DW'(ram_ra),  '0);
        chk("lat_pvld_n1",  DW'(rd_pvld), '0);
        step(); #1;
        chk("lat_pvld_n2",  DW'(rd_pvld),   DW'(1));
        chk("lat_rd_pd",    rd_pd,          pat(1000));
        chk("lat_occ",      DW'(occupancy), DW'(1));
        rd_prdy = 1'b1;
        step(); rd_prdy = 1'b0; #1;
        chk("lat_pvld_done", DW'(rd_pvld), '0);
        chk("lat_idle",      DW'(idle),    DW'(1));

        // Fill 256 back-to-back with consumer stalled
        fill_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_pvld = 1'b1; wr_pd = pat(i); #1;
            if (!wr_prdy) fill_ok = 1'b0;
            step();
        end
        wr_pd = pat(256); #1;
        chk("fill_all_accepted", DW'(fill_ok),   DW'(1));
        chk("full_wr_prdy",      DW'(wr_prdy),   '0);
        chk("full_ram_we",       DW'(ram_we),    '0);
        chk("full_occ",          DW'(occupancy), DW'(256));
        chk("full_rd_pvld",      DW'(rd_pvld),   DW'(1));
        chk("full_rd_pd",        rd_pd,          pat(0));

        // Pop and push together at full: push refused, accepted next cycle
        rd_prdy = 1'b1; #1;
        chk("fullpop_wr_prdy", DW'(wr_prdy), '0);
        step(); rd_prdy = 1'b0; #1;
        chk("fullpop_occ",     DW'(occupancy), DW'(255));
        chk("fullpop_wr_prdy1", DW'(wr_prdy),  DW'(1));
        chk("fullpop_ram_we",  DW'(ram_we),    DW'(1));
        chk("fullpop_rd_pd",   rd_pd,          pat(1));
        step(); wr_pvld = 1'b0; #1;
        chk("refill_occ",      DW'(occupancy), DW'(256));
        chk("refill_wr_prdy",  DW'(wr_prdy),   '0);
        chk("stall_rd_pd",     rd_pd,          pat(1));

        // Drain: one pop per cycle in order
        rd_prdy = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            #1;
            chk("drain_pvld", DW'(rd_pvld), DW'(1));
            chk("drain_pd",   rd_pd,        pat(k));
            step();
        end
        rd_prdy = 1'b0; #1;
        chk("drain_pvld_low", DW'(rd_pvld), '0);
        step(); #1;
        chk("drain_idle", DW'(idle),      DW'(1));
        chk("drain_occ",  DW'(occupancy), '0);

        // Streaming with random handshakes
        sent = 0; rcvd = 0; wraps = 0; cyc = 0; occ_ok = 1'b1;
        while (rcvd < 600 && cyc < 5000) begin
            wr_pvld = (sent < 600) && ($urandom_range(9) < 7);
            wr_pd   = pat(2000 + sent);
            rd_prdy = ($urandom_range(9) < 7);
            #1;
            if (occupancy > 9'd256) occ_ok = 1'b0;
            if (ram_we && ram_wa == '0) wraps++;
            if (wr_pvld && wr_prdy) begin
                sb.push_back(wr_pd);
                sent++;
            end
            if (rd_pvld && rd_prdy) begin
                if (sb.size() > 0) exp_pd = sb.pop_front();
                else exp_pd = '1;
                chk("stream_pd", rd_pd, exp_pd);
                rcvd++;
            end
            step();
            cyc++;
        end
        wr_pvld = 1'b0; rd_prdy = 1'b0;
        chk("stream_count", DW'(rcvd),       DW'(600));
        chk("stream_occ_bound", DW'(occ_ok), DW'(1));
        chk("stream_wraps", DW'(wraps >= 2), DW'(1));

        // Flush with 100 entries and rd_pvld high
        for (int i = 0; i < 100; i++) begin
            wr_pvld = 1'b1; wr_pd = pat(3000 + i);
            step();
        end
        wr_pvld = 1'b0; #1;
        chk("preflush_occ",  DW'(occupancy), DW'(100));
        chk("preflush_pvld", DW'(rd_pvld),   DW'(1));
        flush = 1'b1; rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = pat(3999); #1;
        chk("flush_wr_prdy", DW'(wr_prdy), '0);
        chk("flush_ram_re",  DW'(ram_re),  '0);
        chk("flush_ram_we",  DW'(ram_we),  '0);
        step(); flush = 1'b0; rd_prdy = 1'b0; wr_pvld = 1'b0; #1;
        chk("postflush_occ",  DW'(occupancy), '0);
        chk("postflush_pvld", DW'(rd_pvld),   '0);
        chk("postflush_idle", DW'(idle),      DW'(1));
        wr_pvld = 1'b1; wr_pd = pat(4000); #1;
        chk("postflush_we", DW'(ram_we), DW'(1));
        chk("postflush_wa", DW'(ram_wa), '0);
        step(); wr_pvld = 1'b0;
        step(); #1;
        chk("postflush_rd_pvld", DW'(rd_pvld), DW'(1));
        chk("postflush_rd_pd",   rd_pd,        pat(4000));
        rd_prdy = 1'b1;
        step(); rd_prdy = 1'b0;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            wr_pvld = 1'b1; wr_pd = pat(5000 + i);
            step();
        end
        wr_pd = pat(5003); #1;
        chk("prerst_pvld", DW'(rd_pvld), DW'(1));
        #1 rstn = 1'b0; rd_prdy = 1'b1;
        #1;
        chk("arst_wr_prdy", DW'(wr_prdy),   '0);
        chk("arst_ram_we",  DW'(ram_we),    '0);
        chk("arst_ram_re",  DW'(ram_re),    '0);
        chk("arst_occ",     DW'(occupancy), '0);
        chk("arst_pvld",    DW'(rd_pvld),   '0);
        chk("arst_idle",    DW'(idle),      DW'(1));
        step(); #1;
        chk("arst_hold_we",  DW'(ram_we),    '0);
        chk("arst_hold_re",  DW'(ram_re),    '0);
        chk("arst_hold_occ", DW'(occupancy), '0);
        rstn = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
